// File: rtl/ahb_mem_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter. Losing address phases are parked in
// per-master hold registers and replayed; data phase is steered by the dp owner.
module ahb_mem_arbiter #(
  parameter int P_FIXED_PRI = 0,
  parameter int P_ADDR_W    = 32
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [P_ADDR_W-1:0] M0_HADDR,
  input  logic [1:0]          M0_HTRANS,
  input  logic                M0_HWRITE,
  input  logic [2:0]          M0_HSIZE,
  input  logic [2:0]          M0_HBURST,
  input  logic [31:0]         M0_HWDATA,
  output logic [31:0]         M0_HRDATA,
  output logic                M0_HREADY,
  output logic [1:0]          M0_HRESP,
  input  logic [P_ADDR_W-1:0] M1_HADDR,
  input  logic [1:0]          M1_HTRANS,
  input  logic                M1_HWRITE,
  input  logic [2:0]          M1_HSIZE,
  input  logic [2:0]          M1_HBURST,
  input  logic [31:0]         M1_HWDATA,
  output logic [31:0]         M1_HRDATA,
  output logic                M1_HREADY,
  output logic [1:0]          M1_HRESP,
  output logic                S_HSEL,
  output logic [P_ADDR_W-1:0] S_HADDR,
  output logic [1:0]          S_HTRANS,
  output logic                S_HWRITE,
  output logic [2:0]          S_HSIZE,
  output logic [2:0]          S_HBURST,
  output logic [31:0]         S_HWDATA,
  input  logic [31:0]         S_HRDATA,
  input  logic [1:0]          S_HRESP,
  output logic                S_HREADY,
  input  logic                S_HREADYOUT
);
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef struct packed {
    logic [P_ADDR_W-1:0] addr;
    logic [1:0]          trans;
    logic                write;
    logic [2:0]          size;
    logic [2:0]          burst;
  } addr_ph_t;

  typedef enum logic [1:0] {DP_NONE, DP_M0, DP_M1} dp_e;

  addr_ph_t   live [2];
  addr_ph_t   hold_ph [2];
  logic [1:0] hold_v;
  logic [1:0] live_v;
  logic [1:0] req;
  logic [1:0] hready_int;
  logic [1:0] dp_is;

  dp_e        dp_reg;
  logic       ao_v_reg;
  logic       ao_id_reg;
  logic       rr_last_reg;

  logic       gnt_v;
  logic       gnt_id;
  addr_ph_t   gnt_ph;

  assign live[0] = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HBURST};
  assign live[1] = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HBURST};

  assign dp_is[0] = (dp_reg == DP_M0);
  assign dp_is[1] = (dp_reg == DP_M1);

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic     granted;
    logic     hold_v_reg;
    addr_ph_t hold_reg;

    assign granted        = gnt_v && (gnt_id == 1'(gi));
    assign hready_int[gi] = hold_v_reg ? 1'b0 : (dp_is[gi] ? S_HREADYOUT : 1'b1);
    assign live_v[gi]     = live[gi].trans[1] && hready_int[gi];
    assign req[gi]        = live_v[gi] || hold_v_reg;
    assign hold_v[gi]     = hold_v_reg;
    assign hold_ph[gi]    = hold_reg;

    // A live request that loses (or arrives during a slave wait) is parked here.
    always_ff @(posedge HCLK) begin
      if (HRESET) begin
        hold_v_reg <= 1'b0;
        hold_reg   <= '0;
      end else if (hold_v_reg) begin
        if (granted) hold_v_reg <= 1'b0;
      end else if (live_v[gi] && !granted) begin
        hold_v_reg <= 1'b1;
        hold_reg   <= live[gi];
      end
    end
  end

  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = 1'b0;
    if (S_HREADYOUT) begin
      // The address owner continuing a burst (SEQ/BUSY) cannot be pre-empted.
      if (ao_v_reg && !hold_v[ao_id_reg] &&
          (live[ao_id_reg].trans == TR_SEQ || live[ao_id_reg].trans == TR_BUSY)) begin
        gnt_v  = 1'b1;
        gnt_id = ao_id_reg;
      end else if (req[0] && req[1]) begin
        gnt_v  = 1'b1;
        gnt_id = (P_FIXED_PRI != 0) ? 1'b1 : ~rr_last_reg;
      end else if (req[0] || req[1]) begin
        gnt_v  = 1'b1;
        gnt_id = req[1];
      end
    end
  end

  assign gnt_ph = hold_v[gnt_id] ? hold_ph[gnt_id] : live[gnt_id];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_reg      <= DP_NONE;
      ao_v_reg    <= 1'b0;
      ao_id_reg   <= 1'b0;
      rr_last_reg <= 1'b1;
    end else if (S_HREADYOUT) begin
      ao_v_reg  <= gnt_v;
      ao_id_reg <= gnt_id;
      if (gnt_v && gnt_ph.trans != TR_BUSY)
        dp_reg <= gnt_id ? DP_M1 : DP_M0;
      else
        dp_reg <= DP_NONE;
      if (gnt_v && gnt_ph.trans == TR_NONSEQ)
        rr_last_reg <= gnt_id;
    end
  end

  assign S_HSEL    = gnt_v;
  assign S_HADDR   = gnt_ph.addr;
  assign S_HTRANS  = gnt_v ? gnt_ph.trans : 2'b00;
  assign S_HWRITE  = gnt_ph.write;
  assign S_HSIZE   = gnt_ph.size;
  assign S_HBURST  = gnt_ph.burst;
  assign S_HWDATA  = dp_is[1] ? M1_HWDATA : M0_HWDATA;
  assign S_HREADY  = S_HREADYOUT;

  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign M0_HRESP  = dp_is[0] ? S_HRESP : 2'b00;
  assign M1_HRESP  = dp_is[1] ? S_HRESP : 2'b00;
  assign M0_HREADY = hready_int[0];
  assign M1_HREADY = hready_int[1];

endmodule
